// File: rtl/div_unit_pkg.sv
// Shared types for the iterative RV32M divider: operation encodings and FSM states.
package div_unit_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// Request/response handshake bundle between the execute stage and div_unit.
interface div_unit_if #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 5
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           in_op;
  logic [WIDTH-1:0]     in_dividend;
  logic [WIDTH-1:0]     in_divisor;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_result;
  logic [TAG_WIDTH-1:0] out_tag;

  modport master (
    output flush, in_valid, in_op, in_dividend, in_divisor, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  flush, in_valid, in_op, in_dividend, in_divisor, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/div_unit_step.sv
// One combinational restoring-division iteration on a WIDTH+1-bit shifted remainder.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem, next_bit};
  assign diff    = shifted - {1'b0, divisor};
  // shifted < 2*divisor, so the top bit of diff is set exactly when the subtraction borrows
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Optional DIV_UNIT_FAST_SPECIAL_EN: resolve divide-by-zero and signed overflow at acceptance.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  div_unit_if.slave  bus
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH);

  div_state_e           state;
  logic [WIDTH-1:0]     dvd;
  logic [WIDTH-1:0]     dsr;
  logic [WIDTH-1:0]     prem;
  logic [CW-1:0]        cnt;
  logic                 sel_rem;
  logic                 q_neg;
  logic                 r_neg;
  logic [TAG_WIDTH-1:0] tag;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_result;
  logic [TAG_WIDTH-1:0] out_tag;

  div_op_e          req_op;
  logic             req_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH-1:0] prem_next;
  logic             q_bit;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] result;

  assign req_op     = div_op_e'(bus.in_op);
  assign req_signed = (req_op == OP_DIV) || (req_op == OP_REM);
  assign a_neg      = req_signed & bus.in_dividend[WIDTH-1];
  assign b_neg      = req_signed & bus.in_divisor[WIDTH-1];
  assign a_abs      = a_neg ? -bus.in_dividend : bus.in_dividend;
  assign b_abs      = b_neg ? -bus.in_divisor  : bus.in_divisor;

  // A zero divisor leaves the all-ones quotient unsigned; |MIN| / 1 already yields MIN.
  assign quo_fix = (q_neg && (dsr != '0)) ? -dvd : dvd;
  assign rem_fix = r_neg ? -prem : prem;
  assign result  = sel_rem ? rem_fix : quo_fix;

`ifdef DIV_UNIT_FAST_SPECIAL_EN
  logic             b_zero;
  logic             ovf;
  logic [WIDTH-1:0] special_result;

  assign b_zero = (bus.in_divisor == '0);
  assign ovf    = req_signed && (bus.in_dividend == {1'b1, {(WIDTH-1){1'b0}}})
                             && (bus.in_divisor == '1);
  always_comb begin
    special_result = '0;
    if (b_zero)
      special_result = bus.in_op[1] ? bus.in_dividend : '1;
    else
      special_result = bus.in_op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
  end
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (prem),
    .next_bit (dvd[WIDTH-1]),
    .divisor  (dsr),
    .rem_next (prem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dvd        <= '0;
      dsr        <= '0;
      prem       <= '0;
      cnt        <= '0;
      sel_rem    <= 1'b0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      tag        <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (bus.flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            dvd     <= a_abs;
            dsr     <= b_abs;
            prem    <= '0;
            cnt     <= CNT_INIT;
            sel_rem <= (req_op == OP_REM) || (req_op == OP_REMU);
            q_neg   <= a_neg ^ b_neg;
            r_neg   <= a_neg;
            tag     <= bus.in_tag;
            state   <= BUSY;
`ifdef DIV_UNIT_FAST_SPECIAL_EN
            if (b_zero || ovf) begin
              state      <= DONE;
              out_valid  <= 1'b1;
              out_result <= special_result;
              out_tag    <= bus.in_tag;
            end
`endif
          end
        end
        BUSY: begin
          // Quotient bits enter at the bottom as dividend bits leave the top
          prem <= prem_next;
          dvd  <= {dvd[WIDTH-2:0], q_bit};
          cnt  <= cnt - 1'b1;
          if (cnt == 1) state <= DONE;
        end
        DONE: begin
          if (!out_valid) begin
            out_valid  <= 1'b1;
            out_result <= result;
            out_tag    <= tag;
          end else if (bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = out_valid;
  assign bus.out_result = out_result;
  assign bus.out_tag    = out_tag;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit against an arithmetic RISC-V division model.
module tb_div_unit;

  localparam int WIDTH     = 32;
  localparam int TAG_WIDTH = 5;
`ifdef DIV_UNIT_FAST_SPECIAL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(WIDTH), .TAG_WIDTH(TAG_WIDTH)) bus ();

  div_unit #(.WIDTH(WIDTH), .TAG_WIDTH(TAG_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      2'b00: if (b == 0) return 32'hFFFF_FFFF;
             else if (a == MIN_NEG && b == 32'hFFFF_FFFF) return MIN_NEG;
             else return 32'(sa / sb);
      2'b01: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      2'b10: if (b == 0) return a;
             else if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'h0;
             else return 32'(sa % sb);
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit special;
    special = (b == 0) || (!op[0] && a == MIN_NEG && b == 32'hFFFF_FFFF);
    return (FAST && special) ? 1 : WIDTH + 1;
  endfunction

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.in_op       = op;
    bus.in_dividend = a;
    bus.in_divisor  = b;
    bus.in_tag      = t;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t,
                        output logic [31:0] res, output logic [4:0] rtag, output int lat);
    launch(op, a, b, t);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.out_valid) break;
    end
    res  = bus.out_result;
    rtag = bus.out_tag;
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_result !== 32'h0) begin fails++; $display("[TB] FAIL reset_out_result got %h want 0", bus.out_result); end
    checks++; if (bus.out_tag !== 5'h0) begin fails++; $display("[TB] FAIL reset_out_tag got %h want 0", bus.out_tag); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [1:0]  ops [11] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10};
    logic [31:0] as  [11] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7,
                              32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, MIN_NEG, MIN_NEG};
    logic [31:0] bs  [11] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE,
                              32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [11] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1,
                              32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, MIN_NEG, 32'h0};
    logic [31:0] res;
    logic [4:0]  rtag;
    int          lat;
    for (int i = 0; i < 11; i++) begin
      run_op(ops[i], as[i], bs[i], 5'(i + 3), res, rtag, lat);
      checks++; if (res !== exp[i]) begin fails++; $display("[TB] FAIL directed_result[%0d] got %h want %h", i, res, exp[i]); end
      checks++; if (rtag !== 5'(i + 3)) begin fails++; $display("[TB] FAIL directed_tag[%0d] got %h want %h", i, rtag, 5'(i + 3)); end
      checks++; if (lat !== exp_latency(ops[i], as[i], bs[i])) begin fails++;
        $display("[TB] FAIL directed_latency[%0d] got %0d want %0d", i, lat, exp_latency(ops[i], as[i], bs[i])); end
      finish_op();
      checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL directed_ready_after[%0d] got %b want 1", i, bus.in_ready); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] a, b, res, exp;
    logic [4:0]  rtag;
    int          lat;
    int          bad;
    a = $urandom;
    b = $urandom_range(1, 1000);
    exp = model(2'b01, a, b);
    run_op(2'b01, a, b, 5'h15, res, rtag, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b1 || bus.out_result !== exp || bus.out_tag !== 5'h15 || bus.in_ready !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin fails++;
      $display("[TB] FAIL stall_hold got %0d unstable cycles want 0 (result %h want %h)", bad, bus.out_result, exp); end
    finish_op();
    checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL stall_release_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL stall_release_valid got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back(input int n);
    logic [1:0]  op;
    logic [31:0] a, b, res, exp;
    logic [4:0]  t, rtag;
    int          lat, mode;
    for (int i = 0; i < n; i++) begin
      op   = 2'($urandom_range(0, 3));
      a    = $urandom;
      b    = $urandom;
      t    = 5'($urandom);
      mode = $urandom_range(0, 7);
      if (mode == 0) b = 32'h0;
      else if (mode == 1) begin a = MIN_NEG; b = 32'hFFFF_FFFF; end
      else if (mode == 2) b = $urandom_range(1, 15);
      else if (mode == 3) a = $urandom_range(0, 50);
      exp = model(op, a, b);
      run_op(op, a, b, t, res, rtag, lat);
      checks++; if (res !== exp) begin fails++;
        $display("[TB] FAIL random_result op=%0d a=%h b=%h got %h want %h", op, a, b, res, exp); end
      checks++; if (rtag !== t) begin fails++; $display("[TB] FAIL random_tag got %h want %h", rtag, t); end
      checks++; if (lat !== exp_latency(op, a, b)) begin fails++;
        $display("[TB] FAIL random_latency got %0d want %0d", lat, exp_latency(op, a, b)); end
      finish_op();
    end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    logic [4:0]  rtag;
    int          lat, seen;
    launch(2'b01, 32'd1000, 32'd3, 5'h09);
    repeat (5) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL flush_ready got %b want 1", bus.in_ready); end
    seen = 0;
    for (int i = 0; i < WIDTH + 5; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    checks++; if (seen !== 0) begin fails++; $display("[TB] FAIL flush_no_response got %0d valid cycles want 0", seen); end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL flush_priority got in_ready %b want 1", bus.in_ready); end
    run_op(2'b11, 32'd1000, 32'd3, 5'h0A, res, rtag, lat);
    checks++; if (res !== 32'd1) begin fails++; $display("[TB] FAIL flush_followup got %h want 1", res); end
    finish_op();
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    logic [4:0]  rtag;
    int          lat;
    launch(2'b00, 32'hFFFF_0000, 32'd5, 5'h1F);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL rstmid_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_result !== 32'h0) begin fails++; $display("[TB] FAIL rstmid_out_result got %h want 0", bus.out_result); end
    checks++; if (bus.out_tag !== 5'h0) begin fails++; $display("[TB] FAIL rstmid_out_tag got %h want 0", bus.out_tag); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b01, 32'd9, 32'd3, 5'h04, res, rtag, lat);
    checks++; if (res !== 32'd3) begin fails++; $display("[TB] FAIL rstmid_followup got %h want 3", res); end
    checks++; if (rtag !== 5'h04) begin fails++; $display("[TB] FAIL rstmid_followup_tag got %h want 4", rtag); end
    finish_op();
  endtask

  initial begin
    bus.flush       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_op       = 2'b00;
    bus.in_dividend = '0;
    bus.in_divisor  = '0;
    bus.in_tag      = '0;
    bus.out_ready   = 1'b0;
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back(40);
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
